sseg_scan_driver_gen: RTL

- Parametrised multiplexed seven-segment scan driver for N common-anode digits: hex decode, per-digit enable, decimal points, PWM brightness.
- Frame-synchronous shadow registers remove tearing when display data changes mid-scan.
- Sits between application logic (packed digit bus) and board AN/sseg/DP pins; all pin outputs are registered and active-low.

---
 rtl/sseg_scan_driver_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sseg_scan_driver_gen.sv
// sseg_scan_driver_gen: multiplexed common-anode seven-segment scan driver with frame-synchronous shadowing and PWM dimming.
// Optional: define SSEG_LZ_BLANK_EN for leading-zero suppression. Rev 1.0
`default_nettype none

module sseg_scan_driver_gen #(
  parameter int NUM_DIGITS  = 8,
  parameter int TICK_DIV    = 50000,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    update,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              sseg,
  output logic                    DP,
  output logic                    frame_start,
  output logic                    busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] c_PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] c_IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_AN_ONE = NUM_DIGITS'(1);

  logic [PW-1:0]          r_presc;
  logic [IW-1:0]          r_idx;
  logic [BRIGHT_BITS-1:0] r_pwm;
  logic                   r_pending;
  logic [3:0]             r_sh_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  r_sh_dp;
  logic [NUM_DIGITS-1:0]  r_sh_en;
  logic [NUM_DIGITS-1:0]  r_an;
  logic [6:0]             r_sseg;
  logic                   r_dp;
  logic                   r_frame_start;

  logic                   w_tick;
  logic                   w_wrap;
  logic                   w_lit;
  logic                   w_show;
  logic [NUM_DIGITS-1:0]  w_dig_vis;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
    logic [6:0] v_seg;
    case (i_nib)
      4'h0: v_seg = 7'h40;
      4'h1: v_seg = 7'h79;
      4'h2: v_seg = 7'h24;
      4'h3: v_seg = 7'h30;
      4'h4: v_seg = 7'h19;
      4'h5: v_seg = 7'h12;
      4'h6: v_seg = 7'h02;
      4'h7: v_seg = 7'h78;
      4'h8: v_seg = 7'h00;
      4'h9: v_seg = 7'h10;
      4'hA: v_seg = 7'h08;
      4'hB: v_seg = 7'h03;
      4'hC: v_seg = 7'h46;
      4'hD: v_seg = 7'h21;
      4'hE: v_seg = 7'h06;
      default: v_seg = 7'h0E;
    endcase
    return v_seg;
  endfunction

  assign w_tick = en && (r_presc == c_PRESC_LAST);
  assign w_wrap = w_tick && (r_idx == c_IDX_LAST);
  assign w_lit  = (r_pwm < brightness);

`ifdef SSEG_LZ_BLANK_EN
  logic w_lz_run;

  // Suppression runs downward from the top digit until a nonzero nibble or a lit dp.
  always_comb begin
    w_lz_run  = 1'b1;
    w_dig_vis = r_sh_en;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_lz_run = w_lz_run && (r_sh_dig[k] == 4'h0) && !r_sh_dp[k];
      if (w_lz_run) begin
        w_dig_vis[k] = 1'b0;
      end
    end
  end
`else
  assign w_dig_vis = r_sh_en;
`endif

  assign w_show = en && w_lit && w_dig_vis[r_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_pwm   <= '0;
    end else if (en) begin
      r_pwm   <= r_pwm + 1'b1;
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Shadow copy is only refreshed on the frame wrap, so a frame never mixes old and new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_sh_dp   <= '0;
      r_sh_en   <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_sh_dig[k] <= 4'h0;
      end
    end else if (w_wrap && (r_pending || update)) begin
      r_pending <= 1'b0;
      r_sh_dp   <= dp;
      r_sh_en   <= digit_en;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        r_sh_dig[k] <= digits[4*k +: 4];
      end
    end else if (update) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an          <= '1;
      r_sseg        <= 7'h7F;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_wrap;
      if (w_show) begin
        r_an   <= ~(c_AN_ONE << r_idx);
        r_sseg <= hex_to_seg(r_sh_dig[r_idx]);
        r_dp   <= ~r_sh_dp[r_idx];
      end else begin
        r_an   <= '1;
        r_sseg <= 7'h7F;
        r_dp   <= 1'b1;
      end
    end
  end

  assign AN          = r_an;
  assign sseg        = r_sseg;
  assign DP          = r_dp;
  assign frame_start = r_frame_start;
  assign busy        = r_pending;

endmodule

`default_nettype wire
